// File: rtl/lsu_store_ctrl_if.sv
// rtl/lsu_store_ctrl_if.sv - store request and bus write signals for lsu_store_ctrl
interface lsu_store_ctrl_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  localparam int NB = XLEN / 8;

  logic              i_valid;
  logic              o_ready;
  logic [2:0]        i_funct3;
  logic [ADDR_W-1:0] i_addr;
  logic [XLEN-1:0]   i_data;
  logic              o_bus_req;
  logic              i_bus_ack;
  logic [ADDR_W-1:0] o_bus_addr;
  logic [XLEN-1:0]   o_bus_wdata;
  logic [NB-1:0]     o_bus_be;
  logic              o_done;
  logic              o_trap;
  logic              o_trap_cause;
  logic [ADDR_W-1:0] o_trap_addr;

  // The store controller's view.
  modport slave (
    input  i_valid, i_funct3, i_addr, i_data, i_bus_ack,
    output o_ready, o_bus_req, o_bus_addr, o_bus_wdata, o_bus_be,
           o_done, o_trap, o_trap_cause, o_trap_addr
  );

  modport master (
    output i_valid, i_funct3, i_addr, i_data, i_bus_ack,
    input  o_ready, o_bus_req, o_bus_addr, o_bus_wdata, o_bus_be,
           o_done, o_trap, o_trap_cause, o_trap_addr
  );
endinterface

// File: rtl/lsu_store_ctrl.sv
// rtl/lsu_store_ctrl.sv - store unit: lane placement, misaligned split/trap, bus write beats
module lsu_store_ctrl #(
  parameter int XLEN             = 32,
  parameter int ADDR_W           = 32,
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input logic             i_clk,
  input logic             i_rst,
  lsu_store_ctrl_if.slave bus
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  typedef enum logic [2:0] {IDLE, BEAT0, BEAT1, DONE, TRAP} state_t;

  state_t            state;
  logic [NB-1:0]     be_hi;
  logic [XLEN-1:0]   wd_hi;
  logic [ADDR_W-1:0] addr_hi;

  logic [OFFW-1:0]   off;
  logic [NB-1:0]     size_mask;
  logic [XLEN-1:0]   data_masked;
  logic [2*NB-1:0]   be_wide;
  logic [2*XLEN-1:0] wd_wide;
  logic [4:0]        span;
  logic              misaligned;
  logic              illegal;
  logic [ADDR_W-1:0] base_addr;

  // The request is fully decoded at acceptance; both beats are captured from this.
  always_comb begin
    off         = bus.i_addr[OFFW-1:0];
    size_mask   = '0;
    data_masked = '0;
    for (int i = 0; i < NB; i++) begin
      size_mask[i]         = (i < (1 << bus.i_funct3[1:0]));
      data_masked[8*i +: 8] = size_mask[i] ? bus.i_data[8*i +: 8] : 8'h00;
    end
    be_wide    = {{NB{1'b0}}, size_mask} << off;
    wd_wide    = {{XLEN{1'b0}}, data_masked} << {off, 3'b000};
    span       = 5'(off) + (5'd1 << bus.i_funct3[1:0]);
    misaligned = span > 5'(NB);
    illegal    = bus.i_funct3[2] | ((XLEN == 32) && (bus.i_funct3[1:0] == 2'b11));
    base_addr  = {bus.i_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state            <= IDLE;
      be_hi            <= '0;
      wd_hi            <= '0;
      addr_hi          <= '0;
      bus.o_ready      <= 1'b1;
      bus.o_bus_req    <= 1'b0;
      bus.o_bus_addr   <= '0;
      bus.o_bus_wdata  <= '0;
      bus.o_bus_be     <= '0;
      bus.o_done       <= 1'b0;
      bus.o_trap       <= 1'b0;
      bus.o_trap_cause <= 1'b0;
      bus.o_trap_addr  <= '0;
    end else begin
      bus.o_done <= 1'b0;
      bus.o_trap <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_valid) begin
            bus.o_ready <= 1'b0;
            if (illegal || (misaligned && !SPLIT_MISALIGNED)) begin
              state            <= TRAP;
              bus.o_trap       <= 1'b1;
              bus.o_trap_cause <= illegal;
              bus.o_trap_addr  <= bus.i_addr;
            end else begin
              state           <= BEAT0;
              bus.o_bus_req   <= 1'b1;
              bus.o_bus_addr  <= base_addr;
              bus.o_bus_be    <= be_wide[NB-1:0];
              bus.o_bus_wdata <= wd_wide[XLEN-1:0];
              be_hi           <= be_wide[2*NB-1:NB];
              wd_hi           <= wd_wide[2*XLEN-1:XLEN];
              addr_hi         <= base_addr + ADDR_W'(NB);
            end
          end
        end
        BEAT0: begin
          if (bus.i_bus_ack) begin
            if (be_hi != '0) begin
              state           <= BEAT1;
              bus.o_bus_addr  <= addr_hi;
              bus.o_bus_be    <= be_hi;
              bus.o_bus_wdata <= wd_hi;
            end else begin
              state           <= DONE;
              bus.o_done      <= 1'b1;
              bus.o_bus_req   <= 1'b0;
              bus.o_bus_addr  <= '0;
              bus.o_bus_be    <= '0;
              bus.o_bus_wdata <= '0;
            end
          end
        end
        BEAT1: begin
          if (bus.i_bus_ack) begin
            state           <= DONE;
            bus.o_done      <= 1'b1;
            bus.o_bus_req   <= 1'b0;
            bus.o_bus_addr  <= '0;
            bus.o_bus_be    <= '0;
            bus.o_bus_wdata <= '0;
          end
        end
        DONE: begin
          state       <= IDLE;
          bus.o_ready <= 1'b1;
        end
        TRAP: begin
          state            <= IDLE;
          bus.o_ready      <= 1'b1;
          bus.o_trap_cause <= 1'b0;
          bus.o_trap_addr  <= '0;
        end
        default: begin
          state       <= IDLE;
          bus.o_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_store_ctrl.sv
// tb/tb_lsu_store_ctrl.sv - scoreboard bench for lsu_store_ctrl (split and trap builds)
module tb_lsu_store_ctrl;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  lsu_store_ctrl_if #(.XLEN(32), .ADDR_W(32)) s ();
  lsu_store_ctrl_if #(.XLEN(32), .ADDR_W(32)) t ();

  lsu_store_ctrl #(.XLEN(32), .ADDR_W(32), .SPLIT_MISALIGNED(1'b1)) dut_s (
    .i_clk(i_clk), .i_rst(i_rst), .bus(s.slave));
  lsu_store_ctrl #(.XLEN(32), .ADDR_W(32), .SPLIT_MISALIGNED(1'b0)) dut_t (
    .i_clk(i_clk), .i_rst(i_rst), .bus(t.slave));

  typedef struct {
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
  } beat_t;

  beat_t beat_q[$];
  int    total  = 0;
  int    passed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic void push_beat(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    beat_t b;
    b.a = a; b.be = be; b.wd = wd;
    beat_q.push_back(b);
  endfunction

  // Byte-by-byte reference: each stored byte lands on lane (addr+k) of the beat it falls in.
  function automatic int push_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    logic [7:0]  be8 = '0;
    logic [63:0] wd  = '0;
    int          lane;
    for (int k = 0; k < (1 << f3[1:0]); k++) begin
      lane = int'(a[1:0]) + k;
      be8[lane] = 1'b1;
      wd[lane*8 +: 8] = d[k*8 +: 8];
    end
    push_beat({a[31:2], 2'b00}, be8[3:0], wd[31:0]);
    if (be8[7:4] != 4'h0) begin
      push_beat({a[31:2], 2'b00} + 32'd4, be8[7:4], wd[63:32]);
      return 2;
    end
    return 1;
  endfunction

  task automatic run_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, input int waits, input int exp_done);
    int    cyc = 1;
    int    stall = 0;
    int    done_cyc = 0;
    beat_t b;
    chk({tag, "_ready"}, s.o_ready, 1);
    s.i_valid = 1'b1; s.i_funct3 = f3; s.i_addr = a; s.i_data = d;
    tick();
    s.i_valid = 1'b0; s.i_funct3 = 3'b001; s.i_addr = a ^ 32'h5; s.i_data = ~d;
    while (cyc < 24 && done_cyc == 0) begin
      if (s.o_done) done_cyc = cyc;
      if (s.o_bus_req) begin
        if (beat_q.size() == 0) begin
          chk({tag, "_extra_beat"}, 1, 0);
          s.i_bus_ack = 1'b1;
        end else begin
          b = beat_q[0];
          chk({tag, "_addr"}, s.o_bus_addr, b.a);
          chk({tag, "_be"}, s.o_bus_be, b.be);
          chk({tag, "_wdata"}, s.o_bus_wdata, b.wd);
          chk({tag, "_busy"}, s.o_ready, 0);
          if (stall < waits) begin
            s.i_bus_ack = 1'b0;
            stall++;
          end else begin
            s.i_bus_ack = 1'b1;
            stall = 0;
            void'(beat_q.pop_front());
          end
        end
      end else begin
        s.i_bus_ack = 1'b0;
      end
      if (done_cyc == 0) begin
        tick();
        cyc++;
      end
    end
    s.i_bus_ack = 1'b0;
    chk({tag, "_done_cycle"}, done_cyc, exp_done);
    chk({tag, "_idle_be"}, s.o_bus_be, 0);
    chk({tag, "_idle_wdata"}, s.o_bus_wdata, 0);
    chk({tag, "_left"}, beat_q.size(), 0);
    beat_q.delete();
    tick();
    chk({tag, "_done_pulse"}, s.o_done, 0);
    chk({tag, "_ready_back"}, s.o_ready, 1);
  endtask

  task automatic run_trap(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic cause);
    t.i_valid = 1'b1; t.i_funct3 = f3; t.i_addr = a; t.i_data = 32'h11223344;
    tick();
    t.i_valid = 1'b0; t.i_addr = 32'h0;
    chk({tag, "_trap"}, t.o_trap, 1);
    chk({tag, "_cause"}, t.o_trap_cause, cause);
    chk({tag, "_taddr"}, t.o_trap_addr, a);
    chk({tag, "_noreq"}, t.o_bus_req, 0);
    tick();
    chk({tag, "_trap_pulse"}, t.o_trap, 0);
    chk({tag, "_noreq2"}, t.o_bus_req, 0);
    chk({tag, "_ready"}, t.o_ready, 1);
  endtask

  initial begin
    int          nb;
    int          w;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] d;
    s.i_valid = 0; s.i_funct3 = 0; s.i_addr = 0; s.i_data = 0; s.i_bus_ack = 1;
    t.i_valid = 1; t.i_funct3 = 0; t.i_addr = 0; t.i_data = 0; t.i_bus_ack = 0;
    s.i_valid = 1'b1;
    tick(); tick();
    chk("rst_ready", s.o_ready, 1);
    chk("rst_req", s.o_bus_req, 0);
    chk("rst_be", s.o_bus_be, 0);
    chk("rst_wdata", s.o_bus_wdata, 0);
    chk("rst_addr", s.o_bus_addr, 0);
    chk("rst_done", s.o_done, 0);
    chk("rst_trap", {t.o_trap, t.o_trap_cause, t.o_trap_addr}, 0);
    s.i_valid = 1'b0; s.i_bus_ack = 1'b0; t.i_valid = 1'b0;
    i_rst = 1'b0;
    tick();

    push_beat(32'h1000, 4'b1000, 32'hDD000000);
    run_store("sb", 3'b000, 32'h1003, 32'hAABBCCDD, 0, 2);
    push_beat(32'h2000, 4'b1100, 32'h12340000);
    run_store("sh", 3'b001, 32'h2002, 32'h00001234, 0, 2);
    push_beat(32'h3000, 4'b1000, 32'h44000000);
    push_beat(32'h3004, 4'b0111, 32'h00112233);
    run_store("sw_split", 3'b010, 32'h3003, 32'h11223344, 0, 3);
    push_beat(32'h4000, 4'b1111, 32'hCAFEF00D);
    run_store("sw_stall", 3'b010, 32'h4000, 32'hCAFEF00D, 5, 7);
    nb = push_model(3'b010, 32'hFFFFFFFE, 32'hA1B2C3D4);
    run_store("sw_wrap", 3'b010, 32'hFFFFFFFE, 32'hA1B2C3D4, 1, nb * 2 + 1);

    for (int i = 0; i < 6; i++) begin
      f3 = 3'($urandom_range(0, 2));
      a  = $urandom;
      d  = $urandom;
      w  = $urandom_range(0, 2);
      nb = push_model(f3, a, d);
      run_store($sformatf("rnd%0d", i), f3, a, d, w, nb * (w + 1) + 1);
    end

    run_trap("sw_mis", 3'b010, 32'h3003, 1'b0);
    run_trap("sd_ill", 3'b011, 32'h5000, 1'b1);
    run_trap("f3_ill", 3'b100, 32'h5001, 1'b1);

    // Reset in BEAT1 of the split store, with ack held high to show reset priority.
    s.i_valid = 1'b1; s.i_funct3 = 3'b010; s.i_addr = 32'h3003; s.i_data = 32'h11223344;
    tick();
    s.i_valid = 1'b0; s.i_bus_ack = 1'b1;
    chk("rb_beat0", s.o_bus_addr, 32'h3000);
    tick();
    chk("rb_beat1", s.o_bus_addr, 32'h3004);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0; s.i_bus_ack = 1'b0;
    chk("rb_req", s.o_bus_req, 0);
    chk("rb_ready", s.o_ready, 1);
    chk("rb_done", s.o_done, 0);
    tick();
    chk("rb_done2", s.o_done, 0);
    chk("rb_req2", s.o_bus_req, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/lsu_store_ctrl.md
LSU_STORE_CTRL -- requirements
Module: lsu_store_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
- XLEN, 32, data width; legal values 32 or 64; NB = XLEN/8.
- ADDR_W, 32, address width.
- SPLIT_MISALIGNED, 1, 1 = split misaligned stores into two bus beats; 0 = trap on misaligned stores.
REQ-002 Ports SHALL be, one per line:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  store request valid.
- o_ready  out  1  unit can accept a request.
- i_funct3  in  3  000 SB, 001 SH, 010 SW, 011 SD.
- i_addr  in  ADDR_W  byte address.
- i_data  in  XLEN  store data, right-justified.
- o_bus_req  out  1  bus write request.
- i_bus_ack  in  1  bus accepts the current beat.
- o_bus_addr  out  ADDR_W  beat address, NB-aligned.
- o_bus_wdata  out  XLEN  lane-aligned write data.
- o_bus_be  out  NB  active-high byte enables.
- o_done  out  1  one-cycle pulse when the store completes.
- o_trap  out  1  one-cycle pulse when the store is rejected.
- o_trap_cause  out  1  0 = misaligned, 1 = illegal funct3.
- o_trap_addr  out  ADDR_W  faulting i_addr.

Function
REQ-003 Handshake: a request SHALL be accepted on a rising edge where i_valid=1 and o_ready=1; o_ready SHALL be 1 only in IDLE.
REQ-004 At acceptance, funct3, addr and data SHALL be registered; later changes on the inputs SHALL have no effect.
REQ-005 The FSM SHALL have exactly these states: IDLE, BEAT0, BEAT1, DONE, TRAP.
REQ-006 Illegal funct3 SHALL cause IDLE->TRAP with cause 1. Illegal means funct3[2]=1, or funct3=011 when XLEN=32.
REQ-007 Misaligned means (addr mod NB) + size > NB, where size = 1 << funct3[1:0].
REQ-008 A misaligned store with SPLIT_MISALIGNED=0 SHALL cause IDLE->TRAP with cause 0.
REQ-009 Any other accepted store SHALL cause IDLE->BEAT0.
REQ-010 Lane placement: let off = addr mod NB. Form a 2*NB-bit enable as ((1<<size)-1)<<off. Form 2*XLEN-bit data as the size-masked i_data shifted left by 8*off. Beat0 uses the lower halves; beat1 uses the upper halves.
REQ-011 Beat0 SHALL drive o_bus_addr = addr with the low log2(NB) bits cleared. Beat1 SHALL drive beat0 address + NB, wrapping modulo 2^ADDR_W.
REQ-012 In BEAT0 and BEAT1, o_bus_req SHALL be 1, and o_bus_addr, o_bus_wdata and o_bus_be SHALL stay stable until the edge on which i_bus_ack=1.
REQ-013 On ack in BEAT0: go to BEAT1 if the upper enable half is non-zero, otherwise go to DONE. On ack in BEAT1: go to DONE.
REQ-014 DONE SHALL assert o_done for one cycle and then go to IDLE; it SHALL NOT accept a request in that cycle.
REQ-015 TRAP SHALL assert o_trap for one cycle with o_trap_cause and o_trap_addr valid, assert no o_bus_req, then go to IDLE.
REQ-016 Outside BEAT states, o_bus_req=0, o_bus_be=0 and o_bus_wdata=0.
REQ-017 Latency: an aligned store with zero-wait ack SHALL give o_bus_req in cycle N+1 and o_done in cycle N+2, where N is the accept edge. A split store SHALL give o_done in cycle N+3.
REQ-018 i_bus_ack outside BEAT states SHALL be ignored.

Reset
REQ-019 When i_rst=1 on an edge, the state SHALL be IDLE and o_ready=1. All other outputs SHALL be 0: o_bus_req, o_bus_be, o_bus_wdata, o_bus_addr, o_done, o_trap, o_trap_cause, o_trap_addr. Reset has priority over i_valid and i_bus_ack.
REQ-020 Reset during BEAT0, BEAT1, DONE or TRAP SHALL abort the operation: no o_done and no o_trap for it, and o_bus_req low from the next cycle.

Verification (XLEN=32)
REQ-021 SB, addr 0x1003, data 0xAABBCCDD, zero-wait ack -> one beat: addr 0x1000, be 1000, wdata 0xDD000000; o_done in cycle N+2.
REQ-022 SH, addr 0x2002, data 0x00001234 -> one beat: addr 0x2000, be 1100, wdata 0x12340000.
REQ-023 SW, addr 0x3003, data 0x11223344, SPLIT=1 -> beat0: 0x3000, be 1000, wdata 0x44000000; beat1: 0x3004, be 0111, wdata 0x00112233; then o_done.
REQ-024 Same store with SPLIT=0 -> o_trap=1, cause 0, trap_addr 0x3003, o_bus_req never 1. funct3=011 -> o_trap=1 with cause 1.
REQ-025 SW, addr 0x4000, i_bus_ack held 0 for 5 cycles -> o_bus_req, addr, be and wdata constant for 5 cycles; o_done one cycle after ack.
REQ-026 i_rst pulsed during BEAT1 of the REQ-023 store -> next cycle o_bus_req=0, o_ready=1, no o_done.
